// File: rtl/circ06_pkg.sv
// Shared constants and helpers for the circ06 pipelined two-output datapath.
package circ06_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultDepth = 2;
  localparam bit          DefaultRegU  = 1'b0;

  // Enabled edges from capture to the first cycle the result shows on v.
  function automatic int unsigned lat(input int unsigned depth);
    return 3 + depth;
  endfunction

  // Per-lane value that v produces for one sample.
  function automatic logic lane_v(input logic a, input logic b, input logic c);
    return (a & ~b) | c;
  endfunction

endpackage

// File: rtl/circ06_stage.sv
// One pipeline stage: data register plus valid bit, held while en=0, cleared by rst.
module circ06_stage #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] d_i,
  input  logic             valid_i,
  output logic [Width-1:0] q_o,
  output logic             valid_o
);

  logic [Width-1:0] q_q;
  logic             valid_q;

  // Data follows en regardless of valid; bubbles carry don't-care data.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      q_q     <= d_i;
      valid_q <= valid_i;
    end
  end

  assign q_o     = q_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/circ06_pipe.sv
// WIDTH-lane datapath: u = b & c (optionally registered), v = (a & ~b) | c through a
// three-stage NAND pipeline followed by DEPTH retiming stages.
module circ06_pipe
  import circ06_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  parameter bit          REG_U = DefaultRegU
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] v,
  output logic             v_valid,
  output logic             busy
);

  logic [3*WIDTH-1:0] s1_q;
  logic [2*WIDTH-1:0] s2_q;
  logic [WIDTH-1:0]   a1, nb1, nc1, t2, nc2;
  logic               val1, val2;

  // Index 0 is S3; index DEPTH is the last retiming stage.
  logic [WIDTH-1:0]   v_chain [DEPTH+1];
  logic [DEPTH:0]     val_chain;

  circ06_stage #(
    .Width (3 * WIDTH)
  ) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .d_i     ({a, ~b, ~c}),
    .valid_i (in_valid),
    .q_o     (s1_q),
    .valid_o (val1)
  );

  assign a1  = s1_q[3*WIDTH-1:2*WIDTH];
  assign nb1 = s1_q[2*WIDTH-1:WIDTH];
  assign nc1 = s1_q[WIDTH-1:0];

  circ06_stage #(
    .Width (2 * WIDTH)
  ) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .d_i     ({~(a1 & nb1), nc1}),
    .valid_i (val1),
    .q_o     (s2_q),
    .valid_o (val2)
  );

  assign t2  = s2_q[2*WIDTH-1:WIDTH];
  assign nc2 = s2_q[WIDTH-1:0];

  // ~(~(a & ~b) & ~c) == (a & ~b) | c
  circ06_stage #(
    .Width (WIDTH)
  ) u_s3 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .d_i     (~(t2 & nc2)),
    .valid_i (val2),
    .q_o     (v_chain[0]),
    .valid_o (val_chain[0])
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_retime
    circ06_stage #(
      .Width (WIDTH)
    ) u_r (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .d_i     (v_chain[i]),
      .valid_i (val_chain[i]),
      .q_o     (v_chain[i+1]),
      .valid_o (val_chain[i+1])
    );
  end

  assign v       = v_chain[DEPTH];
  assign v_valid = val_chain[DEPTH];
  assign busy    = val1 | val2 | (|val_chain);

  if (REG_U) begin : g_u_reg
    logic [WIDTH-1:0] u_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        u_q <= '0;
      end else if (en) begin
        u_q <= b & c;
      end
    end

    assign u = u_q;
  end else begin : g_u_comb
    assign u = b & c;
  end

endmodule

// File: tb/tb_circ06_pipe.sv
// Self-checking bench for circ06_pipe: four parameterisations driven in lockstep and
// compared against a sample-history model indexed by enabled edges since reset.
module tb_circ06_pipe;
  import circ06_pkg::*;

  localparam int unsigned D [4] = '{2, 0, 5, 5};
  localparam bit          R [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst, en, in_valid;
  logic [3:0] a, b, c;
  logic [3:0] u_o [4];
  logic [3:0] v_o [4];
  logic       vv_o [4];
  logic       busy_o [4];

  int total = 0;
  int bad   = 0;

  // One entry per enabled edge since the last reset: {valid, expected v}.
  logic [4:0] hist [$];
  logic [3:0] u_model;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    circ06_pipe #(
      .WIDTH (4),
      .DEPTH (D[g]),
      .REG_U (R[g])
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .c        (c),
      .u        (u_o[g]),
      .v        (v_o[g]),
      .v_valid  (vv_o[g]),
      .busy     (busy_o[g])
    );
  end

  function automatic logic exp_valid(input int l);
    int n = hist.size();
    if (n < l) return 1'b0;
    return hist[n-l][4];
  endfunction

  function automatic logic [3:0] exp_v(input int l);
    int n = hist.size();
    if (n < l) return 4'bxxxx;
    return hist[n-l][3:0];
  endfunction

  function automatic logic exp_busy(input int l);
    int n = hist.size();
    for (int j = (n > l) ? n - l : 0; j < n; j++) begin
      if (hist[j][4]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_u(input int i);
    return R[i] ? u_model : (b & c);
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(15));
  endfunction

  task automatic drive(input logic r, input logic e, input logic iv,
                       input logic [3:0] aa, input logic [3:0] bb, input logic [3:0] cc);
    rst = r; en = e; in_valid = iv; a = aa; b = bb; c = cc;
  endtask

  task automatic tick_edge();
    @(posedge clk);
    if (rst) begin
      hist.delete();
      u_model = 4'h0;
    end else if (en) begin
      hist.push_back({in_valid, (a & ~b) | c});
      u_model = b & c;
    end
    #1;
  endtask

  task automatic tick(input logic r, input logic e, input logic iv,
                      input logic [3:0] aa, input logic [3:0] bb, input logic [3:0] cc);
    drive(r, e, iv, aa, bb, cc);
    tick_edge();
  endtask

  task automatic test_reset();
    tick(1'b1, 1'($urandom_range(1)), 1'b1, rnd4(), rnd4(), rnd4());
    tick(1'b1, 1'b0, 1'b1, rnd4(), rnd4(), rnd4());
    for (int i = 0; i < 4; i++) begin
      total++;
      if (v_o[i] !== 4'h0 || vv_o[i] !== 1'b0 || busy_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d: v=%h v_valid=%b busy=%b, required 0/0/0",
                 i, v_o[i], vv_o[i], busy_o[i]);
      end
      total++;
      if (u_o[i] !== (R[i] ? 4'h0 : (b & c))) begin
        bad++;
        $display("FAIL reset_u dut%0d: u=%h required %h", i, u_o[i], R[i] ? 4'h0 : (b & c));
      end
    end
  endtask

  task automatic test_truth_table();
    tick(1'b0, 1'b1, 1'b1, 4'b1100, 4'b1010, 4'b0001);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) tick(1'b0, 1'b1, 1'b0, rnd4(), rnd4(), rnd4());
      total++;
      if (vv_o[0] !== (k == 5)) begin
        bad++;
        $display("FAIL truth_valid edge%0d: v_valid=%b required %b", k, vv_o[0], k == 5);
      end
      if (k == 5) begin
        total++;
        if (v_o[0] !== 4'b0101) begin
          bad++;
          $display("FAIL truth_v: v=%b required 0101", v_o[0]);
        end
      end
    end
  endtask

  task automatic test_streaming();
    int seen = 0;
    for (int k = 0; k < 28; k++) begin
      tick(1'b0, 1'b1, k < 16, rnd4(), rnd4(), rnd4());
      if (vv_o[0] === 1'b1) seen++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (vv_o[i] !== exp_valid(lat(D[i])) || busy_o[i] !== exp_busy(lat(D[i]))) begin
          bad++;
          $display("FAIL stream_ctl dut%0d cyc%0d: v_valid=%b busy=%b required %b/%b", i, k,
                   vv_o[i], busy_o[i], exp_valid(lat(D[i])), exp_busy(lat(D[i])));
        end
        if (vv_o[i] === 1'b1) begin
          total++;
          if (v_o[i] !== exp_v(lat(D[i]))) begin
            bad++;
            $display("FAIL stream_v dut%0d cyc%0d: v=%h required %h", i, k, v_o[i],
                     exp_v(lat(D[i])));
          end
        end
        total++;
        if (u_o[i] !== exp_u(i)) begin
          bad++;
          $display("FAIL stream_u dut%0d cyc%0d: u=%h required %h", i, k, u_o[i], exp_u(i));
        end
      end
    end
    total++;
    if (seen != 16) begin
      bad++;
      $display("FAIL stream_count: v_valid cycles=%0d required 16", seen);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pv [4];
    logic       pvv [4];
    int         seen = 0;
    int         sent = 0;
    for (int k = 0; k < 40; k++) begin
      logic e;
      logic iv;
      e  = (k >= 28) || (k % 4 == 0) || (k % 4 == 3);
      iv = k < 28;
      if (e && iv) sent++;
      for (int i = 0; i < 4; i++) begin
        pv[i]  = v_o[i];
        pvv[i] = vv_o[i];
      end
      tick(1'b0, e, iv, rnd4(), rnd4(), rnd4());
      if (vv_o[0] === 1'b1 && e) seen++;
      for (int i = 0; i < 4; i++) begin
        if (!e) begin
          total++;
          if (v_o[i] !== pv[i] || vv_o[i] !== pvv[i]) begin
            bad++;
            $display("FAIL stall_hold dut%0d cyc%0d: v=%h v_valid=%b required %h/%b", i, k,
                     v_o[i], vv_o[i], pv[i], pvv[i]);
          end
        end
        total++;
        if (vv_o[i] !== exp_valid(lat(D[i])) || busy_o[i] !== exp_busy(lat(D[i]))) begin
          bad++;
          $display("FAIL stall_ctl dut%0d cyc%0d: v_valid=%b busy=%b required %b/%b", i, k,
                   vv_o[i], busy_o[i], exp_valid(lat(D[i])), exp_busy(lat(D[i])));
        end
        if (vv_o[i] === 1'b1) begin
          total++;
          if (v_o[i] !== exp_v(lat(D[i]))) begin
            bad++;
            $display("FAIL stall_v dut%0d cyc%0d: v=%h required %h", i, k, v_o[i],
                     exp_v(lat(D[i])));
          end
        end
      end
    end
    total++;
    if (seen != sent) begin
      bad++;
      $display("FAIL stall_count: v_valid results=%0d required %0d", seen, sent);
    end
  endtask

  task automatic test_midflight_reset();
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b1, rnd4(), rnd4(), rnd4());
    tick(1'b1, 1'b1, 1'b1, rnd4(), rnd4(), rnd4());
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy_o[i] !== 1'b0 || vv_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL midrst_clear dut%0d: busy=%b v_valid=%b required 0/0",
                 i, busy_o[i], vv_o[i]);
      end
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b1, 1'b0, rnd4(), rnd4(), rnd4());
      for (int i = 0; i < 4; i++) begin
        total++;
        if (vv_o[i] !== 1'b0) begin
          bad++;
          $display("FAIL midrst_valid dut%0d cyc%0d: v_valid=%b required 0", i, k, vv_o[i]);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int first [4];
    tick(1'b1, 1'b1, 1'b0, rnd4(), rnd4(), rnd4());
    for (int i = 0; i < 4; i++) first[i] = 0;
    for (int e = 1; e <= 12; e++) begin
      drive(1'b0, 1'b1, e == 1, rnd4(), rnd4(), rnd4());
      #1;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (u_o[i] !== exp_u(i)) begin
          bad++;
          $display("FAIL sweep_u_pre dut%0d edge%0d: u=%h required %h", i, e, u_o[i], exp_u(i));
        end
      end
      tick_edge();
      for (int i = 0; i < 4; i++) begin
        if (first[i] == 0 && vv_o[i] === 1'b1) first[i] = e;
        total++;
        if (u_o[i] !== exp_u(i)) begin
          bad++;
          $display("FAIL sweep_u_post dut%0d edge%0d: u=%h required %h", i, e, u_o[i],
                   exp_u(i));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (first[i] != int'(lat(D[i]))) begin
        bad++;
        $display("FAIL sweep_latency dut%0d (DEPTH=%0d): edges=%0d required %0d",
                 i, D[i], first[i], lat(D[i]));
      end
    end
  endtask

  initial begin
    u_model = 4'h0;
    test_reset();
    test_truth_table();
    test_streaming();
    test_stall();
    test_midflight_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
